// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core and loader request ports plus the memory-side strobes.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ack;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_ack;
    logic [DATA_W-1:0] l_rdata;

    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_ack, l_rdata,
        output wr, rd, addr, wr_data, busy,
        input  rd_data
    );

    // Requester / memory side
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_ack, l_rdata,
        input  wr, rd, addr, wr_data, busy,
        output rd_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core has fixed priority, loader is forced after MAX_WAIT
// consecutive core grants. Each access is strobe, RD_LAT wait (reads only), then a one-cycle ack.
module dmem_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(RD_LAT + 1);
    localparam int unsigned STREAK_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                owner, owner_nxt;
    logic                we, we_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                grant_l;

    logic                wr_q, wr_nxt;
    logic                rd_q, rd_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [DATA_W-1:0]   wr_data_q, wr_data_nxt;
    logic                c_ack_q, c_ack_nxt;
    logic                l_ack_q, l_ack_nxt;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_nxt;
    logic [DATA_W-1:0]   l_rdata_q, l_rdata_nxt;
    logic                busy_q, busy_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            streak    <= '0;
            owner     <= 1'b0;
            we        <= 1'b0;
            cnt       <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            c_ack_q   <= 1'b0;
            l_ack_q   <= 1'b0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            owner     <= owner_nxt;
            we        <= we_nxt;
            cnt       <= cnt_nxt;
            wr_q      <= wr_nxt;
            rd_q      <= rd_nxt;
            addr_q    <= addr_nxt;
            wr_data_q <= wr_data_nxt;
            c_ack_q   <= c_ack_nxt;
            l_ack_q   <= l_ack_nxt;
            c_rdata_q <= c_rdata_nxt;
            l_rdata_q <= l_rdata_nxt;
            busy_q    <= busy_nxt;
        end
    end

    // Next state, arbitration and next output values
    always_comb begin
        state_nxt   = state;
        streak_nxt  = streak;
        owner_nxt   = owner;
        we_nxt      = we;
        cnt_nxt     = cnt;
        addr_nxt    = addr_q;
        wr_data_nxt = wr_data_q;
        c_rdata_nxt = c_rdata_q;
        l_rdata_nxt = l_rdata_q;
        grant_l     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    grant_l     = bus.l_req && (!bus.c_req || (streak >= STREAK_W'(MAX_WAIT)));
                    owner_nxt   = grant_l;
                    we_nxt      = grant_l ? bus.l_we    : bus.c_we;
                    addr_nxt    = grant_l ? bus.l_addr  : bus.c_addr;
                    wr_data_nxt = grant_l ? bus.l_wdata : bus.c_wdata;
                    state_nxt   = ACCESS;
                    // Streak only grows while the loader is actually being passed over
                    if (grant_l || !bus.l_req) begin
                        streak_nxt = '0;
                    end else if (streak < STREAK_W'(MAX_WAIT)) begin
                        streak_nxt = streak + STREAK_W'(1);
                    end
                end
            end
            ACCESS: begin
                if (we) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(RD_LAT);
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                    if (owner) begin
                        l_rdata_nxt = bus.rd_data;
                    end else begin
                        c_rdata_nxt = bus.rd_data;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        wr_nxt    = (state_nxt == ACCESS) && we_nxt;
        rd_nxt    = (state_nxt == ACCESS) && !we_nxt;
        c_ack_nxt = (state_nxt == DONE) && !owner_nxt;
        l_ack_nxt = (state_nxt == DONE) && owner_nxt;
        busy_nxt  = (state_nxt != IDLE);
    end

    assign bus.wr      = wr_q;
    assign bus.rd      = rd_q;
    assign bus.addr    = addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.c_ack   = c_ack_q;
    assign bus.l_ack   = l_ack_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.l_rdata = l_rdata_q;
    assign bus.busy    = busy_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core's load/store port (core) and a debug/program loader port (loader).
- Sequences each access as a one-cycle memory strobe, waits the fixed memory read latency, and returns read data with a one-cycle ack.
- Drives the memory-side signals `wr`, `rd`, `addr`, `wr_data` and consumes `rd_data`, which feed the top-level memory trace outputs.
- Arbitration is fixed priority to the core, with an anti-starvation counter for the loader.

Parameters:
- DATA_W, 32: data width.
- ADDR_W, 9: memory word-address width.
- RD_LAT, 1: memory read latency in cycles (legal 1..4). `rd_data` is valid RD_LAT cycles after the cycle in which `rd` is high.
- MAX_WAIT, 4: consecutive core grants allowed while the loader is requesting before the loader is forced.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  core request; held until c_ack.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_ack  out  1  one-cycle completion pulse to core.
- c_rdata  out  DATA_W  core read data, valid with c_ack.
- l_req, l_we, l_addr, l_wdata, l_ack, l_rdata: loader equivalents, same widths and rules.
- wr  out  1  memory write strobe.
- rd  out  1  memory read strobe.
- addr  out  ADDR_W  memory address.
- wr_data  out  DATA_W  memory write data.
- rd_data  in  DATA_W  memory read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces the following immediately, independent of clk:
  - state=IDLE, streak=0, owner=core;
  - wr=rd=0, addr=0, wr_data=0;
  - c_ack=l_ack=0, c_rdata=l_rdata=0, busy=0.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: a request is accepted on the rising edge where any req=1. On that edge the block latches owner, we, addr and wdata and moves to ACCESS. With no request it stays in IDLE.
- Arbitration when both req=1 at the accept edge:
  - Core wins unless streak >= MAX_WAIT, in which case the loader wins.
  - streak increments (saturating at MAX_WAIT) on each core grant made while l_req=1.
  - streak clears on a loader grant, or on a core grant made while l_req=0.
  - A lone requester always wins.
- ACCESS (exactly one cycle): addr and wr_data show the latched values, and wr=we or rd=!we. Write goes to DONE; read goes to WAIT.
- WAIT: lasts exactly RD_LAT cycles, with a down-counter loaded with RD_LAT on entry. rd_data is captured into the owner's rdata register on the edge ending the last WAIT cycle. Then go to DONE.
- DONE (one cycle): the owner's ack=1, then return to IDLE.
  - Reads: owner rdata is valid in this cycle and is held until the next read by that owner.
  - Writes: rdata is unchanged.
  - The non-owner's ack and rdata are never touched.
- Strobe and data hold: wr and rd are 0 in every state except ACCESS. addr and wr_data hold their last values outside ACCESS.
- Timing, counted from the accept edge E:
  - Write: strobe in cycle 1, ack in cycle 2.
  - Read: strobe in cycle 1, ack in cycle 2+RD_LAT.
  - The minimum accept-to-accept spacing is 3 cycles for a write and 3+RD_LAT for a read, because IDLE always takes one cycle.
- Requester protocol:
  - The requester drops req on the edge ending its ack cycle, or keeps req high to issue a new request.
  - A req that is still high in IDLE counts as a new request.
  - Changes to req, we, addr or wdata after acceptance are ignored until the next IDLE.
- Reset asserted in ACCESS, WAIT or DONE aborts the access:
  - no ack is issued and strobes drop at once;
  - requests still high after release are re-arbitrated with streak=0.
- RD_LAT outside 1..4 is unsupported; the bench does not exercise it.

Test Plan:
1. RD_LAT=1, core read addr 0x010, memory returns 0xDEADBEEF -> rd=1 for exactly cycle 1 with addr=0x010; c_ack=1 only in cycle 3; c_rdata=0xDEADBEEF; l_ack stays 0.
2. Loader write addr 0x1FF, data 0x12345678 -> wr=1 only in cycle 1 with wr_data=0x12345678; l_ack in cycle 2; l_rdata unchanged; busy high in cycles 1-2.
3. MAX_WAIT=4, both req held high continuously, all writes -> grant order C,C,C,C,L,C,C,C,C,L; no two acks in the same cycle.
4. Core and loader each issue one write in the same cycle, streak=0 -> core acked first (cycle 2); loader accepted at the next IDLE edge and acked 3 cycles after the core ack.
5. RD_LAT=3, core read -> rd in cycle 1; rd_data sampled at the end of cycle 4; c_ack in cycle 5.
6. Reset driven low in the WAIT cycle of a core read (RD_LAT=2), released 2 cycles later with c_req still high -> rd, c_ack and busy are 0 during reset; no ack for the aborted access; the read is re-accepted on the first edge after release and completes normally.
